m3_speed_ramp_ctrl: RTL

M3_SPEED_RAMP_CTRL -- requirements
Module: m3_speed_ramp_ctrl

---
 rtl/m3_speed_ramp_ctrl_pkg.sv | 36 +++
 rtl/m3_speed_ramp_ctrl_stall.sv | 30 +++
 rtl/m3_speed_ramp_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/m3_speed_ramp_ctrl_pkg.sv
// Shared motor602 definitions for the M3 speed ramp controller:
// round-length limits, stall defaults and FSM state encoding.
package m3_speed_ramp_ctrl_pkg;

    localparam int unsigned LEN_W   = 32;
    localparam int unsigned STALL_W = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [LEN_W-1:0]   EACH_SLICE_PERIOD_MAX = 32'd20000;
    localparam logic [LEN_W-1:0]   PERIOD_MIN_DEFAULT    = 32'd40;
    localparam logic [STALL_W-1:0] STALL_TICKS_DEFAULT   = 8'd200;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP_UP  = 3'd1,
        ST_CRUISE   = 3'd2,
        ST_RAMP_DN  = 3'd3,
        ST_REVERSE  = 3'd4,
        ST_STOPPING = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    // Saturate a requested round length into [lo, hi].
    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] lo,
        input logic [LEN_W-1:0] hi
    );
        logic [LEN_W-1:0] r;
        r = len;
        if (len < lo) r = lo;
        else if (len > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/m3_speed_ramp_ctrl_stall.sv
// m3_stall_watchdog: counts 100 Hz ticks since the last completed round;
// a round pulse or an idle motor clears it, and the round pulse wins over a tick.
module m3_stall_watchdog
    import m3_speed_ramp_ctrl_pkg::*;
#(
    parameter logic [STALL_W-1:0] STALL_TICKS = STALL_TICKS_DEFAULT
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic i_tick,
    input  logic i_round_done,
    input  logic i_working,
    output logic o_stall_c
);

    logic [STALL_W-1:0] r_cnt;

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_cnt <= '0;
        end else if (!i_working || i_round_done) begin
            r_cnt <= '0;
        end else if (i_tick && (r_cnt < STALL_TICKS)) begin
            r_cnt <= r_cnt + STALL_W'(1);
        end
    end

    assign o_stall_c = (r_cnt >= STALL_TICKS);

endmodule

// File: rtl/m3_speed_ramp_ctrl.sv
// M3 speed ramp controller: tracks a clamped target round length, handles
// reverse, controlled stop, emergency stop and stall fault.
module m3_speed_ramp_ctrl
    import m3_speed_ramp_ctrl_pkg::*;
#(
    parameter logic [STALL_W-1:0] STALL_TICKS = STALL_TICKS_DEFAULT,
    parameter logic [LEN_W-1:0]   PERIOD_MIN  = PERIOD_MIN_DEFAULT
) (
    input  logic               clkI,
    input  logic               nRstI,
    input  logic               clk100hzI,
    input  logic               nextRound_1I,
    input  logic               cmdStartI,
    input  logic               cmdStopI,
    input  logic               cmdForceStopI,
    input  logic               cmdInvI,
    input  logic               cmdClearI,
    input  logic [LEN_W-1:0]   targetRoundLenI,
    input  logic [LEN_W-1:0]   curRoundLenI,
    output logic               workingO,
    output logic               m3speedINCo,
    output logic               m3speedDECo,
    output logic               m3forceStopO,
    output logic               m3invRotateO,
    output logic               atSpeedO,
    output logic               faultO,
    output logic [STATE_W-1:0] stateO
);

    state_t r_state, w_state_nxt;
    logic   r_inv, w_inv_nxt;
    logic   r_working, r_inc, r_dec, r_force, r_at_speed, r_fault;
    logic   w_working_nxt, w_inc_nxt, w_dec_nxt, w_force_nxt, w_at_speed_nxt, w_fault_nxt;

    logic [LEN_W-1:0] w_tgt;
    logic [LEN_W:0]   w_cur_x, w_tgt_x, w_tol_x;
    logic             w_need_inc, w_need_dec, w_at_max, w_stop_req, w_stall_c;

    // Comparisons carried one bit wider so target + tolerance never wraps.
    assign w_tgt      = clamp_len(targetRoundLenI, PERIOD_MIN, EACH_SLICE_PERIOD_MAX);
    assign w_cur_x    = {1'b0, curRoundLenI};
    assign w_tgt_x    = {1'b0, w_tgt};
    assign w_tol_x    = (LEN_W+1)'(curRoundLenI[LEN_W-1:4]);
    assign w_need_inc = w_cur_x > (w_tgt_x + w_tol_x);
    assign w_need_dec = w_tgt_x > (w_cur_x + w_tol_x);
    assign w_at_max   = curRoundLenI >= EACH_SLICE_PERIOD_MAX;
    assign w_stop_req = cmdStopI || !cmdStartI;

    m3_stall_watchdog #(
        .STALL_TICKS (STALL_TICKS)
    ) u_stall (
        .clkI         (clkI),
        .nRstI        (nRstI),
        .i_tick       (clk100hzI),
        .i_round_done (nextRound_1I),
        .i_working    (r_working),
        .o_stall_c    (w_stall_c)
    );

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_state <= ST_IDLE;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_inv   <= w_inv_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_inv_nxt      = r_inv;
        w_working_nxt  = 1'b0;
        w_inc_nxt      = 1'b0;
        w_dec_nxt      = 1'b0;
        w_at_speed_nxt = 1'b0;
        w_fault_nxt    = 1'b0;

        if (cmdForceStopI) begin
            w_state_nxt = ST_IDLE;
        end else if (w_stall_c && r_working) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmdStartI && !cmdStopI) begin
                        w_state_nxt = ST_RAMP_UP;
                        w_inv_nxt   = cmdInvI;
                    end
                end
                ST_RAMP_UP, ST_CRUISE, ST_RAMP_DN: begin
                    if (w_stop_req)              w_state_nxt = ST_STOPPING;
                    else if (cmdInvI != r_inv)   w_state_nxt = ST_REVERSE;
                    else if (w_need_inc)         w_state_nxt = ST_RAMP_UP;
                    else if (w_need_dec)         w_state_nxt = ST_RAMP_DN;
                    else                         w_state_nxt = ST_CRUISE;
                end
                ST_REVERSE: begin
                    if (w_stop_req) begin
                        w_state_nxt = ST_STOPPING;
                    end else if (w_at_max) begin
                        w_state_nxt = ST_RAMP_UP;
                        w_inv_nxt   = ~r_inv;
                    end
                end
                ST_STOPPING: begin
                    if (w_at_max) w_state_nxt = ST_IDLE;
                end
                ST_FAULT: begin
                    if (cmdClearI && !cmdStartI) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the state being entered and registered with it.
        case (w_state_nxt)
            ST_RAMP_UP:  begin w_working_nxt = 1'b1; w_inc_nxt = 1'b1; end
            ST_CRUISE:   begin w_working_nxt = 1'b1; w_at_speed_nxt = 1'b1; end
            ST_RAMP_DN,
            ST_REVERSE,
            ST_STOPPING: begin w_working_nxt = 1'b1; w_dec_nxt = 1'b1; end
            ST_FAULT:    w_fault_nxt = 1'b1;
            default:     w_working_nxt = 1'b0;
        endcase
        w_force_nxt = cmdForceStopI || (w_state_nxt == ST_FAULT);
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_working  <= 1'b0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_force    <= 1'b0;
            r_at_speed <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_working  <= w_working_nxt;
            r_inc      <= w_inc_nxt;
            r_dec      <= w_dec_nxt;
            r_force    <= w_force_nxt;
            r_at_speed <= w_at_speed_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign workingO     = r_working;
    assign m3speedINCo  = r_inc;
    assign m3speedDECo  = r_dec;
    assign m3forceStopO = r_force;
    assign m3invRotateO = r_inv;
    assign atSpeedO     = r_at_speed;
    assign faultO       = r_fault;
    assign stateO       = r_state;

endmodule
